// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU memory port and mem_responder.
//   req_valid/req_ready : request handshake (CPU -> responder)
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address
//   req_size            : 00 byte, 01 half, 10 word, 11 illegal
//   req_wdata           : store data, right-aligned
//   resp_valid/resp_ready : response handshake (responder -> CPU)
//   resp_rdata          : load data, zero-extended, right-aligned
//   resp_err            : request was rejected
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU memory port. Accepts one
// load/store at a time, serves it from an internal word RAM after
// WAIT_CYCLES wait states and returns data or an error.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; clears control and response regs,
//           leaves RAM contents alone
//   bus   : mem_responder_if.slave request/response channels
//   busy  : high while a transaction is in WAIT or RESP
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus,
  output logic           busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [31:0]       rdata_q, rdata_nx;
  logic              err_q, err_nx;
  logic              commit;
  logic              acc_err;

  logic              lat_write;
  logic [ADDR_W+1:0] lat_addr;
  logic [1:0]        lat_size;
  logic [31:0]       lat_wdata;

  logic              c_write;
  logic [ADDR_W+1:0] c_addr;
  logic [1:0]        c_size;
  logic [31:0]       c_wdata;
  logic [31:0]       c_old;

  logic [31:0]       mem [DEPTH];

  function automatic logic req_error(input logic [31:0] addr, input logic [1:0] size);
    logic bad;
    bad = (size == 2'b11) ||
          (size == 2'b01 && addr[0]) ||
          (size == 2'b10 && addr[1:0] != 2'b00);
    if ((addr >> (ADDR_W + 2)) != 32'd0) bad = 1'b1;
    return bad;
  endfunction

  // Half accesses are aligned, so a byte-lane shift of lo*8 also covers them.
  function automatic logic [31:0] load_lane(input logic [31:0] word,
                                            input logic [1:0]  lo,
                                            input logic [1:0]  size);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (size)
      2'b00:   return {24'd0, sh[7:0]};
      2'b01:   return {16'd0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lo,
                                              input logic [1:0]  size);
    logic [31:0] mask;
    logic [31:0] data;
    case (size)
      2'b00:   mask = 32'h0000_00FF;
      2'b01:   mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    mask = mask << {lo, 3'b000};
    data = wdata << {lo, 3'b000};
    return (old & ~mask) | (data & mask);
  endfunction

  assign acc_err = req_error(bus.req_addr, bus.req_size);

  // A zero-wait access commits on the accept edge straight from the request
  // inputs; otherwise the latched copy is used on the edge leaving WAIT.
  always_comb begin
    if (state == IDLE) begin
      c_write = bus.req_write;
      c_addr  = bus.req_addr[ADDR_W+1:0];
      c_size  = bus.req_size;
      c_wdata = bus.req_wdata;
    end else begin
      c_write = lat_write;
      c_addr  = lat_addr;
      c_size  = lat_size;
      c_wdata = lat_wdata;
    end
  end

  assign c_old = mem[c_addr[ADDR_W+1:2]];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rdata_nx = rdata_q;
    err_nx   = err_q;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (acc_err) begin
            state_nx = RESP;
            rdata_nx = 32'd0;
            err_nx   = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            state_nx = RESP;
            commit   = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = RESP;
          commit   = 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (commit) begin
      rdata_nx = c_write ? 32'd0 : load_lane(c_old, c_addr[1:0], c_size);
      err_nx   = 1'b0;
    end
  end

  // Control and response state
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rdata_q <= rdata_nx;
      err_q   <= err_nx;
    end
  end

  // Request capture: only needs to be valid in the accept cycle
  always_ff @(posedge clock) begin
    if (state == IDLE && bus.req_valid) begin
      lat_write <= bus.req_write;
      lat_addr  <= bus.req_addr[ADDR_W+1:0];
      lat_size  <= bus.req_size;
      lat_wdata <= bus.req_wdata;
    end
  end

  // RAM write; reset on the commit edge drops the store
  always_ff @(posedge clock) begin
    if (commit && c_write && !reset)
      mem[c_addr[ADDR_W+1:2]] <= store_merge(c_old, c_wdata, c_addr[1:0], c_size);
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign busy           = (state != IDLE);

endmodule
